// File: rtl/regfile_dump_pkg.sv
// Shared types and constants for the register-file dump engine.
package regfile_dump_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned REG_ADDR_W     = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// Register-file read port, start/status and valid/ready byte stream of the dump engine.
interface regfile_dump_if;
   import regfile_dump_pkg::*;

   logic                  start;
   logic [REG_ADDR_W-1:0] Read_register;
   logic [31:0]           Read_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [7:0]            out_data;
   logic [REG_ADDR_W-1:0] out_index;
   logic                  busy;
   logic                  done;

   // master: the dump engine; slave: register file, byte sink and requester
   modport master (
      input  start, Read_data, out_ready,
      output Read_register, out_valid, out_data, out_index, busy, done
   );

   modport slave (
      output start, Read_data, out_ready,
      input  Read_register, out_valid, out_data, out_index, busy, done
   );

endinterface

// File: rtl/regfile_dump.sv
// Walks registers FIRST_REG..LAST_REG through a spare read port and streams each word
// out MSB-first as four bytes over a valid/ready interface.
module regfile_dump
   import regfile_dump_pkg::*;
#(
   parameter int unsigned FIRST_REG = 0,
   parameter int unsigned LAST_REG  = 31
) (
   input  logic           clk,
   input  logic           reset,
   regfile_dump_if.master bus
);

   localparam logic [REG_ADDR_W-1:0] FIRST_IDX = REG_ADDR_W'(FIRST_REG);
   localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(LAST_REG);
   localparam logic [1:0]            LAST_BYTE = 2'(BYTES_PER_WORD - 1);

   state_t                r_state;
   logic [REG_ADDR_W-1:0] r_index;
   logic [31:0]           r_shift;
   logic [1:0]            r_cnt;
   logic                  r_valid;
   logic                  r_busy;
   logic                  r_done;
   logic                  w_accept;

   assign w_accept = r_valid && bus.out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_index <= '0;
         r_shift <= '0;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_index <= FIRST_IDX;
                  r_busy  <= 1'b1;
                  r_state <= LOAD;
               end
            end
            LOAD: begin
               r_shift <= bus.Read_data;
               r_cnt   <= '0;
               r_valid <= 1'b1;
               r_state <= SEND;
            end
            SEND: begin
               if (w_accept) begin
                  r_shift <= {r_shift[23:0], 8'h00};
                  r_cnt   <= r_cnt + 2'd1;
                  r_valid <= (r_cnt != LAST_BYTE);
                  // Compare before increment so the index never wraps past 31
                  if (r_cnt == LAST_BYTE) begin
                     if (r_index == LAST_IDX) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                     end else begin
                        r_index <= r_index + 1'b1;
                        r_state <= LOAD;
                     end
                  end
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.Read_register = r_index;
   assign bus.out_index     = r_index;
   assign bus.out_data      = r_shift[31:24];
   assign bus.out_valid     = r_valid;
   assign bus.busy          = r_busy;
   assign bus.done          = r_done;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: full range, backpressure, single register, ignored
// starts, mid-dump reset and post-LOAD register writes.
module tb_regfile_dump;
   import regfile_dump_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   regfile_dump_if a_if ();
   regfile_dump_if b_if ();

   logic [31:0] rf_a [32];
   logic [31:0] rf_b [32];

   assign a_if.Read_data = rf_a[a_if.Read_register];
   assign b_if.Read_data = rf_b[b_if.Read_register];

   regfile_dump #(.FIRST_REG(0), .LAST_REG(31)) u_dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (a_if)
   );

   regfile_dump #(.FIRST_REG(29), .LAST_REG(29)) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (b_if)
   );

   logic       sel = 1'b0;
   logic       w_valid, w_busy, w_done;
   logic [7:0] w_data;
   logic [4:0] w_idx;

   always_comb begin
      w_valid = sel ? b_if.out_valid : a_if.out_valid;
      w_busy  = sel ? b_if.busy      : a_if.busy;
      w_done  = sel ? b_if.done      : a_if.done;
      w_data  = sel ? b_if.out_data  : a_if.out_data;
      w_idx   = sel ? b_if.out_index : a_if.out_index;
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive_start(input logic v);
      if (sel) b_if.start = v;
      else     a_if.start = v;
   endtask

   task automatic drive_ready(input logic v);
      if (sel) b_if.out_ready = v;
      else     a_if.out_ready = v;
   endtask

   logic [7:0] got_data [256];
   logic [4:0] got_idx  [256];
   int         got_cyc  [256];
   int         nbytes, done_cnt, done_cyc, busy_low_cyc, first_valid_cyc, hold_err;

   // Cycle numbering: edge 0 samples start; values seen at the negedge after edge c-1
   // belong to cycle c, and a byte seen valid&&ready there is accepted at edge c.
   task automatic run_dump(input logic s, input bit bp, input int reset_at,
                           input bit extra_start, input bit write_r5);
      int         cyc;
      logic       rdy, pv, pr;
      logic [7:0] pd;
      logic [4:0] pi;
      bit         wrote, fin;
      sel = s;
      nbytes = 0; done_cnt = 0; done_cyc = -1; busy_low_cyc = -1;
      first_valid_cyc = -1; hold_err = 0;
      pv = 1'b0; pr = 1'b0; pd = '0; pi = '0; wrote = 1'b0; fin = 1'b0;
      @(negedge clk);
      drive_start(1'b1);
      @(posedge clk);
      cyc = 1;
      while (!fin && cyc < 1000) begin
         @(negedge clk);
         drive_start(extra_start && (cyc == 3 || cyc == 40));
         if (reset_at != 0 && cyc == reset_at) begin
            reset = 1'b0;
            #1;
            check("rst_mid_valid", w_valid, 0);
            check("rst_mid_busy",  w_busy,  0);
            check("rst_mid_data",  w_data,  0);
            check("rst_mid_index", w_idx,   0);
            repeat (3) begin
               @(negedge clk);
               if (w_done) done_cnt++;
            end
            reset = 1'b1;
            fin = 1'b1;
         end else begin
            rdy = !bp || (cyc % 3 == 0);
            drive_ready(rdy);
            if (pv && !pr && w_valid && (w_data !== pd || w_idx !== pi)) hold_err++;
            if (w_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (w_valid && rdy && nbytes < 256) begin
               got_data[nbytes] = w_data;
               got_idx[nbytes]  = w_idx;
               got_cyc[nbytes]  = cyc;
               nbytes++;
            end
            if (write_r5 && !wrote && w_valid && w_idx == 5'd5) begin
               rf_a[5] = 32'hDEAD_BEEF;
               wrote = 1'b1;
            end
            if (w_done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            if (done_cnt > 0 && !w_busy) begin
               busy_low_cyc = cyc;
               fin = 1'b1;
            end
            pv = w_valid; pr = rdy; pd = w_data; pi = w_idx;
            @(posedge clk);
            cyc++;
         end
      end
      drive_ready(1'b0);
      drive_start(1'b0);
      check("run_finished", {31'd0, fin}, 1);
      repeat (3) @(negedge clk);
   endtask

   // Expected stream from the reference register contents, MSB first.
   task automatic verify_bytes(input string tag, input logic s, input int nexp);
      int          reg_i;
      logic [31:0] word;
      logic [7:0]  eb;
      check({tag, "_count"}, nbytes, nexp);
      for (int n = 0; n < nexp && n < nbytes; n++) begin
         reg_i = (s ? 29 : 0) + n / 4;
         word  = s ? ((reg_i == 29) ? 32'h0000_0400 : 32'h0) : 32'h0101_0101 * reg_i;
         eb    = 8'(word >> (8 * (3 - (n % 4))));
         check($sformatf("%s_data%0d", tag, n),  got_data[n], eb);
         check($sformatf("%s_index%0d", tag, n), got_idx[n],  reg_i);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         rf_a[i] = 32'h0101_0101 * i;
         rf_b[i] = (i == 29) ? 32'h0000_0400 : 32'h0;
      end
      a_if.start = 1'b0; a_if.out_ready = 1'b0;
      b_if.start = 1'b0; b_if.out_ready = 1'b0;

      #12;
      check("reset_valid", a_if.out_valid,     0);
      check("reset_busy",  a_if.busy,          0);
      check("reset_done",  a_if.done,          0);
      check("reset_data",  a_if.out_data,      0);
      check("reset_index", a_if.out_index,     0);
      check("reset_raddr", a_if.Read_register, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      run_dump(1'b0, 1'b0, 0, 1'b0, 1'b0);
      verify_bytes("full", 1'b0, 128);
      check("full_first_valid", first_valid_cyc, 2);
      check("full_last_accept", got_cyc[127],    160);
      check("full_done_cyc",    done_cyc,        161);
      check("full_busy_low",    busy_low_cyc,    162);
      check("full_done_cnt",    done_cnt,        1);

      run_dump(1'b0, 1'b1, 0, 1'b0, 1'b0);
      verify_bytes("bp", 1'b0, 128);
      check("bp_hold",        hold_err,     0);
      check("bp_byte1_cyc",   got_cyc[1],   6);
      check("bp_last_accept", got_cyc[127], 384);
      check("bp_done_cyc",    done_cyc,     385);

      run_dump(1'b1, 1'b0, 0, 1'b0, 1'b0);
      verify_bytes("single", 1'b1, 4);
      check("single_cyc0",     got_cyc[0], 2);
      check("single_cyc3",     got_cyc[3], 5);
      check("single_done_cyc", done_cyc,   6);

      run_dump(1'b0, 1'b0, 0, 1'b1, 1'b0);
      check("restart_done_cnt", done_cnt, 1);
      check("restart_bytes",    nbytes,   128);
      check("restart_done_cyc", done_cyc, 161);

      run_dump(1'b0, 1'b0, 50, 1'b0, 1'b0);
      check("rst_no_done", done_cnt, 0);
      run_dump(1'b0, 1'b0, 0, 1'b0, 1'b0);
      verify_bytes("after_rst", 1'b0, 128);
      check("after_rst_done_cyc", done_cyc, 161);

      run_dump(1'b0, 1'b0, 0, 1'b0, 1'b1);
      verify_bytes("late_write", 1'b0, 128);
      check("late_write_applied", rf_a[5], 32'hDEAD_BEEF);
      rf_a[5] = 32'h0505_0505;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
